flash_page_loader: RTL and testbench

FLASH_PAGE_LOADER -- requirements
Module: flash_page_loader

---
 rtl/flash_page_loader.sv | 177 +++++++++++++++++
 tb/tb_flash_page_loader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/flash_page_loader.sv
// Flash page loader: reads one page from a SPI NOR flash with the 0x03 read
// command (SPI mode 0) and streams it, word by word, into a cache SRAM.
module flash_page_loader #(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned PAGE_WORDS = 64,
  localparam int unsigned IDX_W     = $clog2(PAGE_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [23:0]      base_addr_i,
  input  logic             load_i,
  input  logic             invalidate_i,
  output logic             busy_o,
  output logic             cached_o,
  output logic [23:0]      cached_base_o,
  output logic             cache_we_o,
  output logic [IDX_W-1:0] cache_addr_o,
  output logic [31:0]      cache_data_o,
  output logic             flash_csb_o,
  output logic             flash_sck_o,
  output logic             flash_mosi_o,
  input  logic             flash_miso_i
);

  localparam logic [8:0]  DivLast  = 9'(CLK_DIV - 1);
  localparam logic [8:0]  EndLast  = 9'(2 * CLK_DIV - 1);
  localparam logic [13:0] DataLast = 14'(32 * PAGE_WORDS - 1);

  typedef enum logic [2:0] {StIdle, StCmd, StAddr, StData, StEnd} state_e;

  state_e           state_q, state_d;
  logic [8:0]       div_q, div_d;
  logic             sck_q, sck_d;
  logic             csb_q, csb_d;
  logic [31:0]      out_sr_q, out_sr_d;
  logic [31:0]      in_sr_q, in_sr_d;
  logic [4:0]       rx_cnt_q, rx_cnt_d;
  logic [13:0]      bit_cnt_q, bit_cnt_d;
  logic             we_q, we_d;
  logic [31:0]      data_q, data_d;
  logic [IDX_W-1:0] addr_q, addr_d;
  logic             cached_q, cached_d;
  logic [23:0]      base_q, base_d;

  // Byte-lane address bits are dropped: pages are word aligned.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^base_addr_i[1:0];

  // Next-state logic: SCK divider, bit shifting, word assembly and FSM sequencing.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    sck_d     = sck_q;
    csb_d     = csb_q;
    out_sr_d  = out_sr_q;
    in_sr_d   = in_sr_q;
    rx_cnt_d  = rx_cnt_q;
    bit_cnt_d = bit_cnt_q;
    we_d      = 1'b0;
    data_d    = data_q;
    addr_d    = we_q ? addr_q + 1'b1 : addr_q;
    cached_d  = cached_q;
    base_d    = base_q;

    unique case (state_q)
      StIdle: begin
        if (load_i) begin
          state_d   = StCmd;
          csb_d     = 1'b0;
          sck_d     = 1'b0;
          div_d     = '0;
          base_d    = {base_addr_i[23:2], 2'b00};
          // Command and address form one 32-bit MSB-first stream.
          out_sr_d  = {8'h03, base_addr_i[23:2], 2'b00};
          bit_cnt_d = 14'd7;
          rx_cnt_d  = '0;
          addr_d    = '0;
          cached_d  = 1'b0;
        end else if (invalidate_i) begin
          cached_d = 1'b0;
        end
      end
      StCmd, StAddr, StData: begin
        if (div_q == DivLast) begin
          div_d = '0;
          sck_d = ~sck_q;
          if (!sck_q) begin
            // Rising SCK: sample MISO during the data phase.
            if (state_q == StData) begin
              in_sr_d  = {in_sr_q[30:0], flash_miso_i};
              rx_cnt_d = rx_cnt_q + 5'd1;
              if (rx_cnt_q == 5'd31) begin
                we_d   = 1'b1;
                // Bytes arrive first-to-last; first byte lands in bits [7:0].
                data_d = {in_sr_q[6:0], flash_miso_i, in_sr_q[14:7],
                          in_sr_q[22:15], in_sr_q[30:23]};
              end
            end
          end else begin
            // Falling SCK: present the next MOSI bit, close the bit.
            out_sr_d = {out_sr_q[30:0], 1'b0};
            if (bit_cnt_q == '0) begin
              if (state_q == StCmd) begin
                state_d   = StAddr;
                bit_cnt_d = 14'd23;
              end else if (state_q == StAddr) begin
                state_d   = StData;
                bit_cnt_d = DataLast;
              end else begin
                state_d = StEnd;
                csb_d   = 1'b1;
              end
            end else begin
              bit_cnt_d = bit_cnt_q - 14'd1;
            end
          end
        end else begin
          div_d = div_q + 9'd1;
        end
      end
      StEnd: begin
        if (div_q == EndLast) begin
          state_d  = StIdle;
          div_d    = '0;
          cached_d = 1'b1;
        end else begin
          div_d = div_q + 9'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset; reset also aborts any transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      div_q     <= '0;
      sck_q     <= 1'b0;
      csb_q     <= 1'b1;
      out_sr_q  <= '0;
      in_sr_q   <= '0;
      rx_cnt_q  <= '0;
      bit_cnt_q <= '0;
      we_q      <= 1'b0;
      data_q    <= '0;
      addr_q    <= '0;
      cached_q  <= 1'b0;
      base_q    <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      sck_q     <= sck_d;
      csb_q     <= csb_d;
      out_sr_q  <= out_sr_d;
      in_sr_q   <= in_sr_d;
      rx_cnt_q  <= rx_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      we_q      <= we_d;
      data_q    <= data_d;
      addr_q    <= addr_d;
      cached_q  <= cached_d;
      base_q    <= base_d;
    end
  end

  assign busy_o        = (state_q != StIdle);
  assign cached_o      = cached_q;
  assign cached_base_o = base_q;
  assign cache_we_o    = we_q;
  assign cache_addr_o  = addr_q;
  assign cache_data_o  = data_q;
  assign flash_csb_o   = csb_q;
  assign flash_sck_o   = sck_q;
  assign flash_mosi_o  = out_sr_q[31];

endmodule

// File: tb/tb_flash_page_loader.sv
// Directed bench for flash_page_loader with a byte-addressed flash model
// whose contents equal the low byte of each address.
module tb_flash_page_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] base_addr = '0;
  logic        load = 1'b0;
  logic        invalidate = 1'b0;
  logic        busy, cached, cache_we, csb, sck, mosi;
  logic        miso = 1'b0;
  logic [23:0] cached_base;
  logic [1:0]  cache_addr;
  logic [31:0] cache_data;

  int n_tests = 0;
  int n_fail  = 0;

  flash_page_loader #(.CLK_DIV(1), .PAGE_WORDS(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .base_addr_i   (base_addr),
    .load_i        (load),
    .invalidate_i  (invalidate),
    .busy_o        (busy),
    .cached_o      (cached),
    .cached_base_o (cached_base),
    .cache_we_o    (cache_we),
    .cache_addr_o  (cache_addr),
    .cache_data_o  (cache_data),
    .flash_csb_o   (csb),
    .flash_sck_o   (sck),
    .flash_mosi_o  (mosi),
    .flash_miso_i  (miso)
  );

  always #5 clk = ~clk;

  // Flash model and bus monitor, sampled on the falling clk edge.
  int          fbit = 0;
  logic        sck_prev = 1'b0;
  logic [31:0] mosi_word = '0;
  int          wr_cnt = 0;
  int          wr_addr [0:63];
  logic [31:0] wr_data [0:63];
  int          busy_cycles = 0;
  int          csb_hi_busy = 0;
  int          sck_bad = 0;
  int          mosi_bad = 0;

  always @(negedge clk) begin
    if (csb === 1'b1) begin
      fbit = 0;
      miso = 1'b0;
      if (sck === 1'b1) sck_bad++;
    end else if (csb === 1'b0) begin
      if (!sck_prev && sck) begin
        if (fbit < 32) mosi_word = {mosi_word[30:0], mosi};
        fbit++;
      end else if (sck_prev && !sck && fbit >= 32) begin
        int d;
        logic [7:0] byte_v;
        d      = fbit - 32;
        byte_v = 8'(mosi_word[23:0] + 24'(d / 8));
        miso   = byte_v[7 - (d % 8)];
      end
      if (fbit >= 32 && mosi) mosi_bad++;
    end
    sck_prev = sck;
    if (cache_we === 1'b1 && wr_cnt < 64) begin
      wr_addr[wr_cnt] = int'(cache_addr);
      wr_data[wr_cnt] = cache_data;
      wr_cnt++;
    end
    if (busy === 1'b1) begin
      busy_cycles++;
      if (csb === 1'b1) csb_hi_busy++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin
      tick();
      n++;
    end
    if (busy) check_eq("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Pulse load (optionally with invalidate) for one cycle and check acceptance.
  task automatic start_load(input logic [23:0] base, input logic with_inv);
    base_addr  = base;
    load       = 1'b1;
    invalidate = with_inv;
    tick();
    load       = 1'b0;
    invalidate = 1'b0;
    check_eq("accept_busy", 32'(busy), 32'd1);
    check_eq("accept_csb", 32'(csb), 32'd0);
    check_eq("accept_cached", 32'(cached), 32'd0);
    check_eq("accept_mosi", 32'(mosi), 32'd0);
  endtask

  task automatic verify_page(input int w0, input int b0, input int c0,
                             input logic [31:0] exp_stream, input logic [23:0] exp_base);
    check_eq("mosi_stream", mosi_word, exp_stream);
    check_eq("write_count", 32'(wr_cnt - w0), 32'd4);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] exp_w;
      exp_w = {8'(4 * i + 3), 8'(4 * i + 2), 8'(4 * i + 1), 8'(4 * i)};
      check_eq($sformatf("wr_idx%0d", i), 32'(wr_addr[w0 + i]), 32'(i));
      check_eq($sformatf("wr_data%0d", i), wr_data[w0 + i], exp_w);
    end
    check_eq("busy_cycles", 32'(busy_cycles - b0), 32'd322);
    check_eq("end_csb_high", 32'(csb_hi_busy - c0), 32'd2);
    check_eq("cached_set", 32'(cached), 32'd1);
    check_eq("cached_base", 32'(cached_base), 32'(exp_base));
    check_eq("addr_wrapped", 32'(cache_addr), 32'd0);
  endtask

  initial begin
    int w0, b0, c0, n;

    // Reset state
    repeat (3) tick();
    check_eq("rst_csb", 32'(csb), 32'd1);
    check_eq("rst_sck", 32'(sck), 32'd0);
    check_eq("rst_mosi", 32'(mosi), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_cached", 32'(cached), 32'd0);
    check_eq("rst_we", 32'(cache_we), 32'd0);
    check_eq("rst_addr", 32'(cache_addr), 32'd0);
    check_eq("rst_data", cache_data, 32'd0);
    check_eq("rst_base", 32'(cached_base), 32'd0);
    rst = 1'b0;
    repeat (2) tick();

    // Plain page load from 0x000100
    w0 = wr_cnt; b0 = busy_cycles; c0 = csb_hi_busy;
    start_load(24'h000100, 1'b0);
    wait_idle();
    verify_page(w0, b0, c0, 32'h03000100, 24'h000100);

    // Unaligned base: low two bits dropped
    tick();
    w0 = wr_cnt; b0 = busy_cycles; c0 = csb_hi_busy;
    start_load(24'h000203, 1'b0);
    check_eq("unaligned_base", 32'(cached_base), 32'h000200);
    wait_idle();
    verify_page(w0, b0, c0, 32'h03000200, 24'h000200);

    // Loads pulsed during ADDR and during END are ignored
    tick();
    w0 = wr_cnt; b0 = busy_cycles; c0 = csb_hi_busy;
    start_load(24'h000100, 1'b0);
    n = 0;
    while (fbit != 16 && n < 200) begin tick(); n++; end
    check_eq("reach_addr", 32'(fbit), 32'd16);
    base_addr = 24'h000400;
    load = 1'b1;
    tick();
    load = 1'b0;
    n = 0;
    while (!(busy && csb) && n < 1000) begin tick(); n++; end
    check_eq("reach_end", 32'(busy && csb), 32'd1);
    load = 1'b1;
    tick();
    load = 1'b0;
    wait_idle();
    verify_page(w0, b0, c0, 32'h03000100, 24'h000100);
    repeat (5) tick();
    check_eq("no_requeue_busy", 32'(busy), 32'd0);
    check_eq("no_requeue_writes", 32'(wr_cnt - w0), 32'd4);

    // Reset after the second cache write aborts the transaction
    w0 = wr_cnt;
    start_load(24'h000100, 1'b0);
    n = 0;
    while (wr_cnt - w0 < 2 && n < 1000) begin tick(); n++; end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("abort_csb", 32'(csb), 32'd1);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_cached", 32'(cached), 32'd0);
    repeat (100) tick();
    check_eq("abort_writes", 32'(wr_cnt - w0), 32'd2);
    check_eq("abort_cached_late", 32'(cached), 32'd0);
    w0 = wr_cnt; b0 = busy_cycles; c0 = csb_hi_busy;
    start_load(24'h000300, 1'b0);
    wait_idle();
    verify_page(w0, b0, c0, 32'h03000300, 24'h000300);

    // Invalidate in idle, then invalidate together with load
    tick();
    invalidate = 1'b1;
    tick();
    invalidate = 1'b0;
    check_eq("invalidate", 32'(cached), 32'd0);
    check_eq("invalidate_base", 32'(cached_base), 32'h000300);
    w0 = wr_cnt; b0 = busy_cycles; c0 = csb_hi_busy;
    start_load(24'h000100, 1'b1);
    wait_idle();
    verify_page(w0, b0, c0, 32'h03000100, 24'h000100);

    check_eq("sck_idle_low", 32'(sck_bad), 32'd0);
    check_eq("mosi_data_zero", 32'(mosi_bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
